// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - multi-sprite hit test, ROM addressing, animation and priority compositor
// Two pixel_en-gated stages: hit/address generation, then transparency/priority resolution.
module sprite_compositor #(
   parameter int NUM_SPR     = 4,
   parameter int COORD_W     = 10,
   parameter int IDX_W       = 4,
   parameter int STAT_W      = 4,
   parameter int ANIM_FRAMES = 4,
   parameter int FRAME_DIV   = 6,
   parameter int FRAME_PIX   = 4096,
   parameter int ADDR_W      = 18,
   parameter int TRANSP      = 0,
   localparam int ID_W       = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        pixel_en,
   input  logic                        frame_start,
   input  logic [COORD_W-1:0]          DrawX,
   input  logic [COORD_W-1:0]          DrawY,
   input  logic                        blank,
   input  logic [NUM_SPR-1:0]          spr_en,
   input  logic [NUM_SPR*COORD_W-1:0]  spr_x,
   input  logic [NUM_SPR*COORD_W-1:0]  spr_y,
   input  logic [NUM_SPR*COORD_W-1:0]  spr_w,
   input  logic [NUM_SPR*COORD_W-1:0]  spr_h,
   input  logic [NUM_SPR*STAT_W-1:0]   spr_status,
   input  logic [NUM_SPR-1:0]          spr_flip,
   output logic [NUM_SPR*ADDR_W-1:0]   rom_addr,
   input  logic [NUM_SPR*IDX_W-1:0]    rom_data,
   output logic [IDX_W-1:0]            pix_idx,
   output logic                        pix_hit,
   output logic [ID_W-1:0]             pix_id,
   output logic                        blank_out
);

   localparam int AF_W  = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
   localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   logic [AF_W-1:0]   anim_q [NUM_SPR];
   logic [DIV_W-1:0]  div_q  [NUM_SPR];
   logic [STAT_W-1:0] last_q [NUM_SPR];

   logic [NUM_SPR-1:0]        hit_d, hit_q;
   logic [NUM_SPR*ADDR_W-1:0] addr_d, addr_q;
   logic                      blank_q;
   logic [IDX_W-1:0]          idx_d, idx_q;
   logic                      phit_d, phit_q;
   logic [ID_W-1:0]           id_d, id_q;
   logic                      blank_out_q;

   // Animation advances only on frame_start, independent of the pixel strobe.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int c = 0; c < NUM_SPR; c++) begin
            anim_q[c] <= '0;
            div_q[c]  <= '0;
            last_q[c] <= '0;
         end
      end else if (frame_start) begin
         for (int c = 0; c < NUM_SPR; c++) begin
            if (spr_en[c]) begin
               if (spr_status[c*STAT_W +: STAT_W] != last_q[c]) begin
                  last_q[c] <= spr_status[c*STAT_W +: STAT_W];
                  anim_q[c] <= '0;
                  div_q[c]  <= '0;
               end else if (div_q[c] == DIV_W'(FRAME_DIV - 1)) begin
                  div_q[c]  <= '0;
                  anim_q[c] <= (anim_q[c] == AF_W'(ANIM_FRAMES - 1)) ? '0 : anim_q[c] + AF_W'(1);
               end else begin
                  div_q[c] <= div_q[c] + DIV_W'(1);
               end
            end
         end
      end
   end

   always_comb begin
      hit_d  = '0;
      addr_d = '0;
      for (int c = 0; c < NUM_SPR; c++) begin : g_s1
         logic [COORD_W-1:0] sx, sy, sw, sh, lx, ly;
         logic               in_x, in_y;
         sx = spr_x[c*COORD_W +: COORD_W];
         sy = spr_y[c*COORD_W +: COORD_W];
         sw = spr_w[c*COORD_W +: COORD_W];
         sh = spr_h[c*COORD_W +: COORD_W];
         // One extra bit keeps sprites hanging off the right/bottom edge from wrapping to 0.
         in_x = ({1'b0, DrawX} >= {1'b0, sx}) && ({1'b0, DrawX} < ({1'b0, sx} + {1'b0, sw}));
         in_y = ({1'b0, DrawY} >= {1'b0, sy}) && ({1'b0, DrawY} < ({1'b0, sy} + {1'b0, sh}));
         lx = DrawX - sx;
         ly = DrawY - sy;
         if (spr_flip[c]) lx = sw - COORD_W'(1) - lx;
         hit_d[c] = spr_en[c] && (sw != '0) && (sh != '0) && in_x && in_y;
         if (hit_d[c])
            addr_d[c*ADDR_W +: ADDR_W] = ADDR_W'(
               (32'(spr_status[c*STAT_W +: STAT_W]) * 32'(ANIM_FRAMES) + 32'(anim_q[c])) * 32'(FRAME_PIX)
               + 32'(ly) * 32'(sw) + 32'(lx));
      end
   end

   // Descending scan so the lowest-numbered opaque channel is the last (winning) assignment.
   always_comb begin
      idx_d  = '0;
      phit_d = 1'b0;
      id_d   = '0;
      if (blank_q) begin
         for (int c = NUM_SPR - 1; c >= 0; c--) begin
            if (hit_q[c] && (rom_data[c*IDX_W +: IDX_W] != IDX_W'(TRANSP))) begin
               idx_d  = rom_data[c*IDX_W +: IDX_W];
               phit_d = 1'b1;
               id_d   = ID_W'(c);
            end
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         hit_q       <= '0;
         addr_q      <= '0;
         blank_q     <= 1'b0;
         idx_q       <= '0;
         phit_q      <= 1'b0;
         id_q        <= '0;
         blank_out_q <= 1'b0;
      end else if (pixel_en) begin
         hit_q       <= hit_d;
         addr_q      <= addr_d;
         blank_q     <= blank;
         idx_q       <= idx_d;
         phit_q      <= phit_d;
         id_q        <= id_d;
         blank_out_q <= blank_q;
      end
   end

   assign rom_addr  = addr_q;
   assign pix_idx   = idx_q;
   assign pix_hit   = phit_q;
   assign pix_id    = id_q;
   assign blank_out = blank_out_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - directed and randomized checks of sprite_compositor against a behavioural model
module tb_sprite_compositor;
   localparam int NS = 4, CW = 10, IW = 4, SW = 4, AF = 4, FD = 6, FP = 4096, AW = 18, TR = 0;

   logic Clk = 0, Reset = 1, pixel_en = 0, frame_start = 0, blank = 1;
   logic [CW-1:0] DrawX = 0, DrawY = 0;
   logic [NS-1:0] spr_en = 0, spr_flip = 0;
   logic [NS*CW-1:0] spr_x = 0, spr_y = 0, spr_w = 0, spr_h = 0;
   logic [NS*SW-1:0] spr_status = 0;
   logic [NS*AW-1:0] rom_addr;
   logic [NS*IW-1:0] rom_data = 0;
   logic [IW-1:0] pix_idx;
   logic pix_hit, blank_out;
   logic [1:0] pix_id;

   int checks = 0, failures = 0;

   sprite_compositor dut (
      .Clk(Clk), .Reset(Reset), .pixel_en(pixel_en), .frame_start(frame_start),
      .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .spr_en(spr_en),
      .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h),
      .spr_status(spr_status), .spr_flip(spr_flip), .rom_addr(rom_addr), .rom_data(rom_data),
      .pix_idx(pix_idx), .pix_hit(pix_hit), .pix_id(pix_id), .blank_out(blank_out));

   always #5 Clk = ~Clk;

   // Behavioural model: animation frame = (frame pulses since last status change / FD) mod AF.
   int cnt [NS];
   int lst [NS];
   bit s1_hit [NS];
   bit s1_blank;
   int e_addr [NS];
   int e_idx, e_id;
   bit e_hit, e_blank;

   function automatic int fld(input logic [NS*CW-1:0] v, input int c);
      return int'(v[c*CW +: CW]);
   endfunction

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int c = 0; c < NS; c++) begin cnt[c] = 0; lst[c] = 0; s1_hit[c] = 0; e_addr[c] = 0; end
         s1_blank = 0; e_idx = 0; e_id = 0; e_hit = 0; e_blank = 0;
      end else begin
         if (pixel_en) begin
            e_hit = 0; e_idx = 0; e_id = 0; e_blank = s1_blank;
            if (s1_blank)
               for (int c = 0; c < NS; c++)
                  if (!e_hit && s1_hit[c] && int'(rom_data[c*IW +: IW]) != TR) begin
                     e_hit = 1; e_idx = int'(rom_data[c*IW +: IW]); e_id = c;
                  end
            for (int c = 0; c < NS; c++) begin
               int x, y, w, h, dx, dy, lx, st;
               x = fld(spr_x, c); y = fld(spr_y, c); w = fld(spr_w, c); h = fld(spr_h, c);
               dx = int'(DrawX); dy = int'(DrawY); st = int'(spr_status[c*SW +: SW]);
               s1_hit[c] = spr_en[c] && dx >= x && dx < x + w && dy >= y && dy < y + h;
               lx = spr_flip[c] ? (w - 1 - (dx - x)) : (dx - x);
               e_addr[c] = s1_hit[c] ?
                  (((st * AF + (cnt[c] / FD) % AF) * FP + (dy - y) * w + lx) % (1 << AW)) : 0;
            end
            s1_blank = blank;
         end
         if (frame_start)
            for (int c = 0; c < NS; c++)
               if (spr_en[c]) begin
                  if (int'(spr_status[c*SW +: SW]) != lst[c]) begin
                     lst[c] = int'(spr_status[c*SW +: SW]); cnt[c] = 0;
                  end else cnt[c]++;
               end
      end
   end

   always @(negedge Clk) begin
      bit ok;
      ok = (int'(pix_idx) == e_idx) && (pix_hit == e_hit) && (int'(pix_id) == e_id) && (blank_out == e_blank);
      for (int c = 0; c < NS; c++) if (int'(rom_addr[c*AW +: AW]) != e_addr[c]) ok = 0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL model t=%0t: got idx=%0d hit=%0d id=%0d blank_out=%0d addr=%h want idx=%0d hit=%0d id=%0d blank_out=%0d addr0..3=%0d,%0d,%0d,%0d",
                  $time, pix_idx, pix_hit, pix_id, blank_out, rom_addr, e_idx, e_hit, e_id, e_blank,
                  e_addr[0], e_addr[1], e_addr[2], e_addr[3]);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic pe, input logic fs);
      pixel_en = pe; frame_start = fs;
      @(posedge Clk); #1;
      pixel_en = 0; frame_start = 0;
   endtask

   task automatic set_spr(input int c, input logic en, input int x, input int y, input int w, input int h,
                          input int st, input logic fl);
      spr_en[c] = en; spr_flip[c] = fl;
      spr_x[c*CW +: CW] = CW'(x); spr_y[c*CW +: CW] = CW'(y);
      spr_w[c*CW +: CW] = CW'(w); spr_h[c*CW +: CW] = CW'(h);
      spr_status[c*SW +: SW] = SW'(st);
   endtask

   function automatic int addr0();
      return int'(rom_addr[AW-1:0]);
   endfunction

   initial begin
      repeat (2) @(posedge Clk);
      #1;
      chk("reset_pix_idx", int'(pix_idx), 0);
      chk("reset_pix_hit", int'(pix_hit), 0);
      chk("reset_rom_addr", int'(rom_addr != 0), 0);
      chk("reset_blank_out", int'(blank_out), 0);
      Reset = 0;

      set_spr(0, 1, 100, 50, 16, 16, 0, 0);
      DrawX = 100; DrawY = 50; step(1, 0);
      chk("t1_addr_tl", addr0(), 0);
      DrawX = 115; DrawY = 65; rom_data = 16'h0005; step(1, 0);
      chk("t1_addr_br", addr0(), 255);
      chk("t1_pix_idx", int'(pix_idx), 5);
      chk("t1_pix_hit", int'(pix_hit), 1);
      DrawX = 116; rom_data = 16'h0009; step(1, 0);
      chk("t1_addr_miss", addr0(), 0);
      chk("t1_pix_idx2", int'(pix_idx), 9);
      step(1, 0);
      chk("t1_miss_hit", int'(pix_hit), 0);
      chk("t1_blank_out", int'(blank_out), 1);

      spr_flip[0] = 1;
      DrawX = 100; DrawY = 50; step(1, 0);
      chk("t2_flip_tl", addr0(), 15);
      DrawX = 115; step(1, 0);
      chk("t2_flip_tr", addr0(), 0);
      DrawY = 65; step(1, 0);
      chk("t2_flip_br", addr0(), 240);
      spr_flip[0] = 0;

      set_spr(2, 1, 100, 50, 16, 16, 0, 0);
      DrawX = 105; DrawY = 52; step(1, 0);
      rom_data = 16'h0700; step(1, 0);
      chk("t3_transp_idx", int'(pix_idx), 7);
      chk("t3_transp_id", int'(pix_id), 2);
      rom_data = 16'h0703; step(1, 0);
      chk("t3_prio_idx", int'(pix_idx), 3);
      chk("t3_prio_id", int'(pix_id), 0);
      spr_en[2] = 0;

      DrawX = 100; DrawY = 50; blank = 0; step(1, 0);
      blank = 1; rom_data = 16'h0006; step(1, 0);
      chk("t5_blank_hit", int'(pix_hit), 0);
      chk("t5_blank_idx", int'(pix_idx), 0);
      chk("t5_blank_out", int'(blank_out), 0);
      step(1, 0);
      chk("t5_unblank_idx", int'(pix_idx), 6);

      DrawX = 102; DrawY = 51; rom_data = 16'h0004; step(1, 0);
      step(1, 0);
      repeat (10) begin
         DrawX = CW'($urandom); DrawY = CW'($urandom); rom_data = 16'($urandom); blank = 1'($urandom);
         step(0, 0);
      end
      chk("t6_hold_idx", int'(pix_idx), 4);
      chk("t6_hold_hit", int'(pix_hit), 1);
      chk("t6_hold_addr", addr0(), 18);
      chk("t6_hold_blank", int'(blank_out), 1);
      blank = 1;
      @(posedge Clk); #2;
      Reset = 1; #1;
      chk("t6_rst_idx", int'(pix_idx), 0);
      chk("t6_rst_hit", int'(pix_hit), 0);
      chk("t6_rst_addr", addr0(), 0);
      chk("t6_rst_blank", int'(blank_out), 0);
      @(posedge Clk); #1;
      Reset = 0;

      set_spr(0, 1, 100, 50, 16, 16, 0, 0);
      DrawX = 100; DrawY = 50;
      repeat (6) step(0, 1);
      step(1, 0);
      chk("t4_anim1", addr0(), 4096);
      repeat (18) step(0, 1);
      step(1, 0);
      chk("t4_wrap", addr0(), 0);
      repeat (8) step(0, 1);
      spr_status[SW-1:0] = 4'd2; step(1, 0);
      chk("t4_new_status_old_frame", addr0(), 36864);
      step(0, 1); step(1, 0);
      chk("t4_status_reset", addr0(), 32768);

      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 149) == 0)
            for (int c = 0; c < NS; c++) begin
               if ($urandom_range(0, 5) == 0)
                  set_spr(c, 1'($urandom), 1000 + $urandom_range(0, 23), $urandom_range(0, 120),
                          $urandom_range(1, 60), $urandom_range(0, 40), $urandom_range(0, 15), 1'($urandom));
               else
                  set_spr(c, $urandom_range(0, 4) != 0, $urandom_range(60, 200), $urandom_range(30, 120),
                          $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 3), 1'($urandom));
            end
         if ($urandom_range(0, 299) == 0) spr_status[$urandom_range(0, NS-1)*SW +: SW] = SW'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) DrawX = CW'($urandom);
         else DrawX = CW'($urandom_range(50, 250));
         DrawY = CW'($urandom_range(20, 170));
         for (int c = 0; c < NS; c++) rom_data[c*IW +: IW] = ($urandom_range(0, 1) == 0) ? IW'(TR) : IW'($urandom);
         blank = $urandom_range(0, 9) != 0;
         if (n == 2500) begin
            @(posedge Clk); #2;
            Reset = 1;
            @(posedge Clk); #1;
            Reset = 0;
         end
         step($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      end

      @(negedge Clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
